// File: rtl/frame_level_meter_if.sv
// ---------------------------------------------------------------------------
// frame_level_meter_if
//   Bundle between mic_sampler (master) and frame_level_meter (slave).
//   done          : frame-ready level; a rising edge marks a new frame
//   s0..s15       : 18-bit signed samples, valid on the cycle done rises
//   leds          : 10-LED log bar graph with peak dot (leds[0] = lowest)
//   frame_valid   : one-cycle pulse when leds updates
//   ovr           : sticky flag, a frame was dropped while busy
// ---------------------------------------------------------------------------
interface frame_level_meter_if;
  logic               done;
  logic signed [17:0] s0,  s1,  s2,  s3,  s4,  s5,  s6,  s7;
  logic signed [17:0] s8,  s9,  s10, s11, s12, s13, s14, s15;
  logic [9:0]         leds;
  logic               frame_valid;
  logic               ovr;

  modport master (
    output done,
    output s0, s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, s12, s13, s14, s15,
    input  leds, frame_valid, ovr
  );

  modport slave (
    input  done,
    input  s0, s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, s12, s13, s14, s15,
    output leds, frame_valid, ovr
  );
endinterface

// File: rtl/frame_level_meter.sv
// ---------------------------------------------------------------------------
// frame_level_meter
//   Per captured microphone frame: mean absolute amplitude over 16 cycles,
//   peak-hold with exponential decay, and a 10-LED log-scale bar graph with
//   a peak dot.
//   clk_25 : 25 MHz system clock
//   rst_n  : asynchronous active-low reset
//   bus    : frame_level_meter_if.slave (done, s0..s15 in; leds,
//            frame_valid, ovr out)
//   LED k lights when the value reaches 2^(THR_BASE+k).
// ---------------------------------------------------------------------------
module frame_level_meter #(
  parameter int THR_BASE    = 8,
  parameter int HOLD_FRAMES = 2,
  parameter int DECAY_SHIFT = 1
) (
  input logic                 clk_25,
  input logic                 rst_n,
  frame_level_meter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, UPDATE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_done_q;
  logic               w_capture;

  logic signed [17:0] w_samples [16];
  logic signed [17:0] r_snap    [16];

  logic [21:0]        r_sum;
  logic [3:0]         r_idx;
  logic [17:0]        r_avg;
  logic [17:0]        r_peak;
  logic [3:0]         r_hold;
  logic [9:0]         r_leds;
  logic               r_frame_valid;
  logic               r_ovr;

  logic [17:0]        w_cur;
  logic [17:0]        w_mag;
  logic [17:0]        w_avg_now;
  logic [17:0]        w_peak_dec;
  logic [9:0]         w_bar;
  logic [9:0]         w_dot;

  assign w_samples[0]  = bus.s0;
  assign w_samples[1]  = bus.s1;
  assign w_samples[2]  = bus.s2;
  assign w_samples[3]  = bus.s3;
  assign w_samples[4]  = bus.s4;
  assign w_samples[5]  = bus.s5;
  assign w_samples[6]  = bus.s6;
  assign w_samples[7]  = bus.s7;
  assign w_samples[8]  = bus.s8;
  assign w_samples[9]  = bus.s9;
  assign w_samples[10] = bus.s10;
  assign w_samples[11] = bus.s11;
  assign w_samples[12] = bus.s12;
  assign w_samples[13] = bus.s13;
  assign w_samples[14] = bus.s14;
  assign w_samples[15] = bus.s15;

  // A frame starts only on a rising edge of done; a level held high is ignored.
  assign w_capture = bus.done & ~r_done_q;

  // Magnitude as 18-bit unsigned: -131072 negates to 2^17, which still fits.
  assign w_cur      = r_snap[r_idx];
  assign w_mag      = w_cur[17] ? (~w_cur + 18'd1) : w_cur;
  assign w_avg_now  = r_sum[21:4];
  assign w_peak_dec = r_peak >> DECAY_SHIFT;

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives the signal; no latch.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_state_nxt = ACCUM;
      ACCUM:   if (r_idx == 4'd15) w_state_nxt = SCALE;
      SCALE:   w_state_nxt = UPDATE;
      UPDATE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Display encoding: bar from the frame average, one-hot dot from the peak.
  // The loop runs low to high so the last hit is the highest threshold.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_bar = '0;
    w_dot = '0;
    for (int k = 0; k < 10; k++) begin
      if ({14'd0, r_avg}  >= (32'd1 << (THR_BASE + k))) w_bar[k] = 1'b1;
      if ({14'd0, r_peak} >= (32'd1 << (THR_BASE + k))) w_dot = 10'd1 << k;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample snapshot
  // NOTE: storage array is deliberately not reset; it is always written on
  // capture before it is read, so a reset would only cost flops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25) begin
    if (r_state == IDLE && w_capture) begin
      for (int k = 0; k < 16; k++) r_snap[k] <= w_samples[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge values of the others, independent of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q      <= 1'b0;
      r_sum         <= '0;
      r_idx         <= '0;
      r_avg         <= '0;
      r_peak        <= '0;
      r_hold        <= '0;
      r_leds        <= '0;
      r_frame_valid <= 1'b0;
      r_ovr         <= 1'b0;
    end else begin
      r_done_q      <= bus.done;
      r_frame_valid <= 1'b0;

      // Any new frame arriving outside IDLE (UPDATE included) is dropped.
      if (w_capture && r_state != IDLE) r_ovr <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_sum <= '0;
            r_idx <= '0;
          end
        end
        ACCUM: begin
          r_sum <= r_sum + {4'd0, w_mag};
          r_idx <= r_idx + 4'd1;
        end
        SCALE: begin
          r_avg <= w_avg_now;
          if (w_avg_now >= r_peak) begin
            r_peak <= w_avg_now;
            r_hold <= 4'(HOLD_FRAMES);
          end else if (r_hold != 4'd0) begin
            r_hold <= r_hold - 4'd1;
          end else if (w_peak_dec != 18'd0) begin
            r_peak <= r_peak - w_peak_dec;
          end else if (r_peak != 18'd0) begin
            // Shift decay has bottomed out; step the last counts down to zero.
            r_peak <= r_peak - 18'd1;
          end
        end
        UPDATE: begin
          r_leds        <= w_bar | w_dot;
          r_frame_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.leds        = r_leds;
  assign bus.frame_valid = r_frame_valid;
  assign bus.ovr         = r_ovr;

endmodule
